clk_phase_gen: RTL

Parametrised multi-channel clock generator. It produces N_CH registered clocks from the master clock, replacing the fixed divide-by-4 and inverted-clock scheme. Each channel has a programmable half-period, phase offset and inversion, and an enable strobe for logic that runs on the master clock. A valid/ready config port reconfigures channels without glitches, and a sync input realigns all channels. It sits at the top level and feeds the imem, dmem, processor and regfile clock domains.

---
 rtl/clk_gen_pkg.sv | 32 +++
 rtl/clk_chan.sv | 70 +++++++
 rtl/clk_phase_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types, reset defaults and helpers for the multi-channel clock generator.
package clk_gen_pkg;

  localparam int unsigned CG_HALF_W   = 4;
  localparam int unsigned CG_DEF_HALF = 2;

  typedef struct packed {
    logic [CG_HALF_W-1:0] half;
    logic [CG_HALF_W-1:0] phase;
    logic                 inv;
  } chan_cfg_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } cfg_state_t;

  localparam chan_cfg_t CFG_RESET = '{
    half:  CG_HALF_W'(CG_DEF_HALF),
    phase: '0,
    inv:   1'b0
  };

  // Keep the phase strictly inside the counter range 0..half-1.
  function automatic logic [CG_HALF_W-1:0] clamp_phase(
    input logic [CG_HALF_W-1:0] half,
    input logic [CG_HALF_W-1:0] phase
  );
    clamp_phase = (phase >= half) ? (half - CG_HALF_W'(1)) : phase;
  endfunction

endpackage

// File: rtl/clk_chan.sv
// One generated clock channel: half-period counter, toggle bit, registered clock and tick.
module clk_chan
  import clk_gen_pkg::*;
#(
  parameter int unsigned DEF_HALF = CG_DEF_HALF
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      sync,
  input  logic      load_now,
  input  chan_cfg_t cfg,
  output logic      clk_out,
  output logic      tick,
  output logic      at_boundary
);

  chan_cfg_t            cur_q;
  chan_cfg_t            cur_d;
  logic [CG_HALF_W-1:0] cnt_q;
  logic [CG_HALF_W-1:0] cnt_d;
  logic                 raw_q;
  logic                 raw_d;
  logic                 clk_d;
  logic                 tick_d;
  logic                 wrap;

  assign wrap        = (cnt_q == (cur_q.half - CG_HALF_W'(1)));
  // raw falls on the next edge: the only safe point to swap configurations
  assign at_boundary = raw_q & wrap;

  always_comb begin
    cur_d  = cur_q;
    cnt_d  = cnt_q + CG_HALF_W'(1);
    raw_d  = raw_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (load_now) begin
      cur_d = cfg;
    end
    if (sync) begin
      cnt_d = cur_d.phase;
      raw_d = 1'b0;
    end else if (load_now) begin
      cnt_d = '0;
      raw_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      raw_d = ~raw_q;
    end
    clk_d  = raw_d ^ cur_d.inv;
    tick_d = clk_d & ~clk_out & ~sync;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_q   <= '{half: CG_HALF_W'(DEF_HALF), phase: '0, inv: 1'b0};
      cnt_q   <= '0;
      raw_q   <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      clk_out <= clk_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-channel clock generator with a glitch-free valid/ready reconfiguration port and sync realign.
module clk_phase_gen
  import clk_gen_pkg::*;
#(
  parameter  int unsigned N_CH     = 4,
  parameter  int unsigned HALF_W   = CG_HALF_W,
  parameter  int unsigned DEF_HALF = CG_DEF_HALF,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic [HALF_W-1:0] cfg_phase,
  input  logic              cfg_inv,
  output logic              cfg_err,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  localparam int unsigned SEL_N = 1 << CH_W;

  cfg_state_t      state_q;
  cfg_state_t      state_d;
  chan_cfg_t       req_cfg;
  chan_cfg_t       pend_cfg;
  chan_cfg_t       apply_cfg;
  logic [CH_W-1:0] pend_chan;
  logic [CH_W-1:0] apply_chan;
  logic [SEL_N-1:0] chan_exists;
  logic [N_CH-1:0] at_boundary;
  logic [N_CH-1:0] load_now;
  logic            accept;
  logic            req_ok;
  logic            pend_vld;
  logic            pend_ld;
  logic            err_d;

  // Channel select codes beyond N_CH-1 are rejected
  always_comb begin
    chan_exists = '0;
    for (int unsigned i = 0; i < SEL_N; i++) begin
      chan_exists[i] = (i < N_CH);
    end
  end

  assign accept   = cfg_valid & cfg_ready;
  assign req_ok   = (cfg_half != '0) & chan_exists[cfg_chan];
  assign pend_vld = (state_q == ST_PEND);

  always_comb begin
    req_cfg       = CFG_RESET;
    req_cfg.half  = CG_HALF_W'(cfg_half);
    req_cfg.phase = clamp_phase(CG_HALF_W'(cfg_half), CG_HALF_W'(cfg_phase));
    req_cfg.inv   = cfg_inv;
  end

  // A pending config lands at its channel's period end or at sync; a fresh one only at sync
  always_comb begin
    apply_cfg  = pend_vld ? pend_cfg  : req_cfg;
    apply_chan = pend_vld ? pend_chan : cfg_chan;
    load_now   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (apply_chan == CH_W'(i)) begin
        if (pend_vld) begin
          load_now[i] = sync | at_boundary[i];
        end else begin
          load_now[i] = sync & accept & req_ok;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_ld = 1'b0;
    err_d   = accept & ~req_ok;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && req_ok && !sync) begin
          state_d = ST_PEND;
          pend_ld = 1'b1;
        end
      end
      ST_PEND: begin
        if (|load_now) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      pend_chan <= '0;
      pend_cfg  <= CFG_RESET;
    end else begin
      state_q   <= state_d;
      cfg_ready <= (state_d == ST_IDLE);
      cfg_err   <= err_d;
      if (pend_ld) begin
        pend_chan <= cfg_chan;
        pend_cfg  <= req_cfg;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clk_chan #(
      .DEF_HALF(DEF_HALF)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .sync       (sync),
      .load_now   (load_now[g]),
      .cfg        (apply_cfg),
      .clk_out    (clk_out[g]),
      .tick       (tick[g]),
      .at_boundary(at_boundary[g])
    );
  end

endmodule
